// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Optional two's complement mode is enabled with SEQ_MULT_SIGNED_EN.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// One combinational add-and-shift iteration of the multiplier datapath.
// The upper half takes the conditional sum, the lower half shifts in its LSB.
module shift_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    always_comb begin
        addend  = lo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}};
        // One extra bit keeps the carry, which shifts into the top of hi.
        sum     = {1'b0, hi} + addend;
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH cycles per product, IDLE/CALC/DONE FSM.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_t state;
    state_t state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] p_next;

    shift_add_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .hi     (hi),
        .lo     (lo),
        .mcand  (mcand),
        .hi_next(hi_next),
        .lo_next(lo_next)
    );

    assign prod = {hi_next, lo_next};

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;

    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;
    assign p_next = neg ? -prod : prod;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign p_next = prod;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // p is written only from the final step, so partial sums never appear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            p     <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        lo    <= b_mag;
                        hi    <= '0;
                        cnt   <= CNT_LOAD;
`ifdef SEQ_MULT_SIGNED_EN
                        neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        p <= p_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: cycle-level timeline model for WIDTH=4, directed WIDTH=8 runs.
// Expected products follow SEQ_MULT_SIGNED_EN when it is defined.
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [7:0] p4;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    function automatic logic [7:0] f4(input logic [3:0] x, input logic [3:0] y);
        int r;
`ifdef SEQ_MULT_SIGNED_EN
        r = int'($signed(x)) * int'($signed(y));
`else
        r = int'(x) * int'(y);
`endif
        return r[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Timeline model: an accepted start at edge e0 gives busy for edges
    // e0..e0+4, done and the new product at e0+4, acceptance again at e0+6.
    int         e = 0;
    int         e0 = -1000;
    logic [7:0] m_prod = '0;
    logic [7:0] m_p = '0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    always @(posedge clk) begin
        e++;
        if (rst) begin
            e0  = -1000;
            m_p = '0;
        end else if (start4 && (e - e0) >= 6) begin
            e0     = e;
            m_prod = f4(a4, b4);
        end
        m_busy = (e - e0) >= 0 && (e - e0) <= 4;
        m_done = (e - e0) == 4;
        if (m_done) m_p = m_prod;
    end

    always @(negedge clk) begin
        chk("cyc_busy", {31'd0, busy4}, {31'd0, m_busy});
        chk("cyc_done", {31'd0, done4}, {31'd0, m_done});
        chk("cyc_p", {24'd0, p4}, {24'd0, m_p});
    end

    task automatic run4(input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] exp_p, input string nm);
        int  n;
        bit  seen;
        start4 = 1'b1;
        a4 = x;
        b4 = y;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        chk({nm, "_busy"}, {31'd0, busy4}, 32'd1);
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk({nm, "_lat"}, n, 32'd4);
        chk({nm, "_p"}, {24'd0, p4}, {24'd0, exp_p});
        @(posedge clk); #1;
        chk({nm, "_idle"}, {31'd0, busy4}, 32'd0);
        chk({nm, "_hold"}, {24'd0, p4}, {24'd0, exp_p});
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp_p, input string nm);
        int  n;
        bit  seen;
        start8 = 1'b1;
        a8 = x;
        b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk({nm, "_lat"}, n, 32'd8);
        chk({nm, "_p"}, {16'd0, p8}, {16'd0, exp_p});
        @(posedge clk); #1;
        chk({nm, "_idle"}, {31'd0, busy8}, 32'd0);
    endtask

    logic [7:0] order [256];
    logic [7:0] tmp;
    int         j;
    int         seen_done;

    initial begin
        chk("model_D_5", {24'd0, f4(4'hD, 4'h5)}, SIGNED_MODE ? 32'hF1 : 32'h41);
        chk("model_8_8", {24'd0, f4(4'h8, 4'h8)}, 32'h40);
        chk("model_7_8", {24'd0, f4(4'h7, 4'h8)}, SIGNED_MODE ? 32'hC8 : 32'h38);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_p4", {24'd0, p4}, 32'd0);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_p8", {16'd0, p8}, 32'd0);

        run4(4'hF, 4'hF, SIGNED_MODE ? 8'h01 : 8'hE1, "f_x_f");
        run8(8'd0, 8'd200, 16'd0, "zero_x_200");
        run8(8'hFF, 8'hFF, SIGNED_MODE ? 16'h0001 : 16'd65025, "ff_x_ff");
        run4(4'hD, 4'h5, SIGNED_MODE ? 8'hF1 : 8'h41, "d_x_5");
        run4(4'h8, 4'h8, 8'h40, "8_x_8");
        run4(4'h7, 4'h8, SIGNED_MODE ? 8'hC8 : 8'h38, "7_x_8");

        // Mid-CALC reset: asserted for the third CALC cycle.
        start4 = 1'b1;
        a4 = 4'h9;
        b4 = 4'h9;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        start4 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start4 = 1'b0;
        chk("midrst_p", {24'd0, p4}, 32'd0);
        chk("midrst_busy", {31'd0, busy4}, 32'd0);
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4) seen_done++;
        end
        chk("midrst_nodone", seen_done, 32'd0);

        // start held high with operands changing every cycle.
        start4 = 1'b1;
        repeat (30) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            @(posedge clk); #1;
        end
        start4 = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 256; i++) order[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            tmp = order[i];
            run4(tmp[7:4], tmp[3:0], f4(tmp[7:4], tmp[3:0]), "sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
